// File: rtl/jram_scanner_if.sv
// jram_scanner_if
// Groups the control, jRAM bus and display signals of the jRAM read-back
// scanner so they can be passed as one port.
//   slave  : the scanner itself (controls and DATA_IN in, bus/status/word out)
//   master : whoever drives the controls and models the RAM (bench or top)
// Signals:
//   start_i, stop_i, loop_i, step_i, next_i : scan controls
//   data_in_i  [7:0]  : jRAM output bus
//   addr_o     [7:0]  : address driven to the jRAM
//   sa_o, ena_o       : jRAM address-latch set / output enable
//   data_q_o   [7:0]  : last captured byte
//   valid_o, busy_o, done_o : capture pulse, non-idle flag, end-of-scan pulse
//   word_o     [31:0] : four ASCII characters for the 7-segment display
interface jram_scanner_if;
    logic        start_i;
    logic        stop_i;
    logic        loop_i;
    logic        step_i;
    logic        next_i;
    logic [7:0]  data_in_i;
    logic [7:0]  addr_o;
    logic        sa_o;
    logic        ena_o;
    logic [7:0]  data_q_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] word_o;

    modport slave (
        input  start_i, stop_i, loop_i, step_i, next_i, data_in_i,
        output addr_o, sa_o, ena_o, data_q_o, valid_o, busy_o, done_o, word_o
    );

    modport master (
        output start_i, stop_i, loop_i, step_i, next_i, data_in_i,
        input  addr_o, sa_o, ena_o, data_q_o, valid_o, busy_o, done_o, word_o
    );
endinterface

// File: rtl/jram_scanner.sv
// jram_scanner
// Walks the jRAM from FIRST_ADDR to LAST_ADDR, latching each address (SA),
// enabling the output (ENA), capturing the byte and holding the pair for
// display, either for DWELL cycles or until NEXT when STEP is set.
// Ports:
//   clk_i  : system clock
//   rstn_i : synchronous active-low reset
//   bus    : jram_scanner_if.slave (controls, jRAM bus, status, display word)
// Optional build macro JRAM_SCANNER_HEX_WORD_EN: word_o shows the address
// and data as four lowercase hex characters instead of " rd "/" idl".
//
// state | meaning
// IDLE  | not scanning, SA/ENA low, ADDR/DATA_Q held
// LATCH | SA high for SETTLE cycles
// READ  | ENA high for SETTLE cycles, capture on the last one
// SHOW  | hold pair for DWELL cycles, or until NEXT in step mode
module jram_scanner #(
    parameter int unsigned DWELL      = 50000000,
    parameter int unsigned SETTLE     = 2,
    parameter logic [7:0]  FIRST_ADDR = 8'd0,
    parameter logic [7:0]  LAST_ADDR  = 8'd255
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    jram_scanner_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_READ  = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    // Down-counters are loaded with length-1 so the terminal count is zero.
    localparam logic [31:0] SETTLE_TC = 32'(SETTLE - 1);
    localparam logic [31:0] DWELL_TC  = 32'(DWELL - 1);

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;
    logic        sa_q;
    logic        ena_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic        show_exit;

    // Step mode ignores the timer entirely; it is re-evaluated every cycle.
    assign show_exit = bus.step_i ? bus.next_i : (cnt_q == 32'd0);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            addr_q  <= 8'd0;
            data_q  <= 8'd0;
            sa_q    <= 1'b0;
            ena_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != S_IDLE && bus.stop_i) begin
                state_q <= S_IDLE;
                sa_q    <= 1'b0;
                ena_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start_i && !bus.stop_i) begin
                            addr_q  <= FIRST_ADDR;
                            state_q <= S_LATCH;
                            sa_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            cnt_q   <= SETTLE_TC;
                        end
                    end
                    S_LATCH: begin
                        if (cnt_q == 32'd0) begin
                            state_q <= S_READ;
                            sa_q    <= 1'b0;
                            ena_q   <= 1'b1;
                            cnt_q   <= SETTLE_TC;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    S_READ: begin
                        if (cnt_q == 32'd0) begin
                            state_q <= S_SHOW;
                            ena_q   <= 1'b0;
                            data_q  <= bus.data_in_i;
                            valid_q <= 1'b1;
                            cnt_q   <= DWELL_TC;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    S_SHOW: begin
                        if (cnt_q != 32'd0) begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                        if (show_exit) begin
                            cnt_q <= SETTLE_TC;
                            if (addr_q != LAST_ADDR) begin
                                addr_q  <= addr_q + 8'd1;
                                state_q <= S_LATCH;
                                sa_q    <= 1'b1;
                            end else if (bus.loop_i) begin
                                addr_q  <= FIRST_ADDR;
                                state_q <= S_LATCH;
                                sa_q    <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.addr_o   = addr_q;
    assign bus.data_q_o = data_q;
    assign bus.sa_o     = sa_q;
    assign bus.ena_o    = ena_q;
    assign bus.valid_o  = valid_q;
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;

`ifdef JRAM_SCANNER_HEX_WORD_EN
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_char = 8'h30 + {4'd0, nib};
        end else begin
            hex_char = 8'h57 + {4'd0, nib};
        end
    endfunction

    assign bus.word_o = {hex_char(addr_q[7:4]), hex_char(addr_q[3:0]),
                         hex_char(data_q[7:4]), hex_char(data_q[3:0])};
`else
    assign bus.word_o = busy_q ? " rd " : " idl";
`endif

endmodule

// File: tb/tb_jram_scanner.sv
module tb_jram_scanner;

    localparam int DWELL  = 4;
    localparam int SETTLE = 2;

    logic clk_i = 1'b0;
    logic rstn_i;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] ram [0:3];

    jram_scanner_if bus ();

    jram_scanner #(
        .DWELL      (DWELL),
        .SETTLE     (SETTLE),
        .FIRST_ADDR (8'd0),
        .LAST_ADDR  (8'd3)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        bus.data_in_i = 8'hxx;
        if (bus.addr_o < 8'd4) bus.data_in_i = ram[bus.addr_o[1:0]];
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.loop_i  = 1'b0;
        bus.step_i  = 1'b0;
        bus.next_i  = 1'b0;
        rstn_i = 1'b0;
        tick();
        tick();
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.addr_o, bus.data_q_o, bus.sa_o, bus.ena_o, bus.valid_o, bus.busy_o, bus.done_o} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%h data=%h sa=%b ena=%b valid=%b busy=%b done=%b, want all 0",
                     bus.addr_o, bus.data_q_o, bus.sa_o, bus.ena_o, bus.valid_o, bus.busy_o, bus.done_o);
        end
`ifdef JRAM_SCANNER_HEX_WORD_EN
        checks++;
        if (bus.word_o !== "0000") begin
            errors++;
            $display("FAIL reset_word: got %h want %h", bus.word_o, 32'("0000"));
        end
`else
        checks++;
        if (bus.word_o !== " idl") begin
            errors++;
            $display("FAIL reset_word: got %h want %h", bus.word_o, 32'(" idl"));
        end
`endif
    endtask

    // Cycle c counts cycles after the START edge; address i occupies
    // cycles 8i+1..8i+8: SA in phase 0-1, ENA in 2-3, SHOW in 4-7.
    task automatic test_single_scan();
        int i, p;
        logic exp_sa, exp_ena, exp_valid, exp_busy, exp_done;
        logic [7:0] exp_addr;
        do_reset();
        bus.start_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            bus.start_i = 1'b0;
            i = (c - 1) / 8;
            p = (c - 1) % 8;
            exp_busy  = (c <= 32);
            exp_sa    = exp_busy && (p < 2);
            exp_ena   = exp_busy && (p == 2 || p == 3);
            exp_valid = exp_busy && (p == 4);
            exp_done  = (c == 33);
            exp_addr  = exp_busy ? 8'(i) : 8'd3;
            checks++;
            if ({bus.sa_o, bus.ena_o, bus.valid_o, bus.busy_o, bus.done_o, bus.addr_o} !==
                {exp_sa, exp_ena, exp_valid, exp_busy, exp_done, exp_addr}) begin
                errors++;
                $display("FAIL scan_ctrl c=%0d: sa/ena/valid/busy/done=%b%b%b%b%b addr=%h, want %b%b%b%b%b addr=%h",
                         c, bus.sa_o, bus.ena_o, bus.valid_o, bus.busy_o, bus.done_o, bus.addr_o,
                         exp_sa, exp_ena, exp_valid, exp_busy, exp_done, exp_addr);
            end
            if (exp_valid) begin
                checks++;
                if (bus.data_q_o !== ram[i]) begin
                    errors++;
                    $display("FAIL scan_data c=%0d: got %h want %h", c, bus.data_q_o, ram[i]);
                end
            end
`ifndef JRAM_SCANNER_HEX_WORD_EN
            checks++;
            if (bus.word_o !== (exp_busy ? 32'(" rd ") : 32'(" idl"))) begin
                errors++;
                $display("FAIL scan_word c=%0d: got %h busy=%b", c, bus.word_o, exp_busy);
            end
`endif
        end
    endtask

    task automatic test_loop();
        int i, p;
        do_reset();
        bus.loop_i  = 1'b1;
        bus.start_i = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            tick();
            bus.start_i = 1'b0;
            i = (c - 1) / 8;
            p = (c - 1) % 8;
            checks++;
            if (bus.addr_o !== 8'(i % 4) || bus.valid_o !== (p == 4) || bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL loop_ctrl c=%0d: addr=%h valid=%b done=%b busy=%b, want addr=%h valid=%b done=0 busy=1",
                         c, bus.addr_o, bus.valid_o, bus.done_o, bus.busy_o, 8'(i % 4), (p == 4));
            end
            if (p == 4) begin
                checks++;
                if (bus.data_q_o !== ram[i % 4]) begin
                    errors++;
                    $display("FAIL loop_data c=%0d: got %h want %h", c, bus.data_q_o, ram[i % 4]);
                end
            end
        end
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        bus.loop_i = 1'b0;
    endtask

    task automatic test_step();
        logic [7:0] exp_data [0:1];
        exp_data[0] = 8'h22;
        exp_data[1] = 8'h33;
        do_reset();
        bus.step_i  = 1'b1;
        bus.start_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.start_i = 1'b0;
        end
        checks++;
        if (bus.valid_o !== 1'b1 || bus.data_q_o !== 8'h11) begin
            errors++;
            $display("FAIL step_first: valid=%b data=%h want 1/11", bus.valid_o, bus.data_q_o);
        end
        for (int n = 0; n < 2; n++) begin
            for (int w = 0; w < 20; w++) begin
                tick();
                checks++;
                if (bus.valid_o !== 1'b0 || bus.sa_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.addr_o !== 8'(n)) begin
                    errors++;
                    $display("FAIL step_hold n=%0d w=%0d: valid=%b sa=%b busy=%b addr=%h want 0/0/1/%h",
                             n, w, bus.valid_o, bus.sa_o, bus.busy_o, bus.addr_o, 8'(n));
                end
            end
            bus.next_i = 1'b1;
            tick();
            bus.next_i = 1'b0;
            checks++;
            if (bus.sa_o !== 1'b1 || bus.addr_o !== 8'(n + 1)) begin
                errors++;
                $display("FAIL step_advance n=%0d: sa=%b addr=%h want 1/%h", n, bus.sa_o, bus.addr_o, 8'(n + 1));
            end
            for (int c = 2; c <= 5; c++) begin
                tick();
                checks++;
                if (bus.valid_o !== (c == 5)) begin
                    errors++;
                    $display("FAIL step_valid n=%0d c=%0d: got %b want %b", n, c, bus.valid_o, (c == 5));
                end
            end
            checks++;
            if (bus.data_q_o !== exp_data[n]) begin
                errors++;
                $display("FAIL step_data n=%0d: got %h want %h", n, bus.data_q_o, exp_data[n]);
            end
        end
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        bus.step_i = 1'b0;
    endtask

    task automatic test_stop();
        do_reset();
        bus.start_i = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            bus.start_i = (c == 10);   // ignored while busy
        end
        checks++;
        if (bus.ena_o !== 1'b1 || bus.addr_o !== 8'd2) begin
            errors++;
            $display("FAIL stop_pre: ena=%b addr=%h want 1/02", bus.ena_o, bus.addr_o);
        end
        bus.stop_i  = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.stop_i  = 1'b0;
        bus.start_i = 1'b0;
        for (int w = 0; w < 10; w++) begin
            checks++;
            if ({bus.sa_o, bus.ena_o, bus.valid_o, bus.busy_o, bus.done_o} !== 5'b0 ||
                bus.data_q_o !== 8'h22 || bus.addr_o !== 8'd2) begin
                errors++;
                $display("FAIL stop_idle w=%0d: sa/ena/valid/busy/done=%b%b%b%b%b data=%h addr=%h want 00000 22 02",
                         w, bus.sa_o, bus.ena_o, bus.valid_o, bus.busy_o, bus.done_o, bus.data_q_o, bus.addr_o);
            end
            tick();
        end
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        checks++;
        if (bus.addr_o !== 8'd0 || bus.sa_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL stop_restart: addr=%h sa=%b busy=%b want 00/1/1", bus.addr_o, bus.sa_o, bus.busy_o);
        end
        for (int c = 2; c <= 5; c++) tick();
        checks++;
        if (bus.valid_o !== 1'b1 || bus.data_q_o !== 8'h11) begin
            errors++;
            $display("FAIL stop_restart_data: valid=%b data=%h want 1/11", bus.valid_o, bus.data_q_o);
        end
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        bus.start_i = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            bus.start_i = 1'b0;
        end
        // c=21 captured 0x33 at address 2; c=22 is still SHOW
`ifdef JRAM_SCANNER_HEX_WORD_EN
        checks++;
        if (bus.word_o !== "0233") begin
            errors++;
            $display("FAIL hex_word: got %h want %h", bus.word_o, 32'("0233"));
        end
`endif
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        checks++;
        if ({bus.addr_o, bus.data_q_o, bus.sa_o, bus.ena_o, bus.valid_o, bus.busy_o, bus.done_o} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid_show: addr=%h data=%h sa=%b ena=%b valid=%b busy=%b done=%b, want all 0",
                     bus.addr_o, bus.data_q_o, bus.sa_o, bus.ena_o, bus.valid_o, bus.busy_o, bus.done_o);
        end
`ifdef JRAM_SCANNER_HEX_WORD_EN
        checks++;
        if (bus.word_o !== "0000") begin
            errors++;
            $display("FAIL reset_mid_show_word: got %h want %h", bus.word_o, 32'("0000"));
        end
`endif
    endtask

    task automatic test_start_stop_idle();
        do_reset();
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (bus.busy_o !== 1'b0 || bus.sa_o !== 1'b0) begin
                errors++;
                $display("FAIL start_stop_idle w=%0d: busy=%b sa=%b want 0/0", w, bus.busy_o, bus.sa_o);
            end
            tick();
        end
    endtask

    initial begin
        ram[0] = 8'h11;
        ram[1] = 8'h22;
        ram[2] = 8'h33;
        ram[3] = 8'h44;
        test_reset();
        test_single_scan();
        test_loop();
        test_step();
        test_stop();
        test_reset_mid_show();
        test_start_stop_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
